uart_rx_fifo_cfg: RTL
=====================

// Module: uart_rx_fifo_cfg
// PURPOSE
//  Parametrised UART receiver with a 2-FF input synchroniser and mid-bit sampling.
//  Runtime-selectable frame format: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
//  Received bytes and error flags go into an RX FIFO drained over a valid/ready port.
//  Sits in the peripheral subsystem between the pad and the bus-side UART register block.
// PARAMETERS
//  CLK_FREQ     50000000  system clock in Hz
//  BAUD_RATE    115200    reset baud; DEFAULT_BIT_PERIOD = CLK_FREQ/BAUD_RATE-1
//  FIFO_DEPTH   8         RX FIFO entries; power of 2, >=2
//  SYNC_STAGES  2         rxd synchroniser flops, >=2
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    synchronous, active-low reset
//  cfg_wr_i         in   1    load cfg_bit_period_i; aborts the frame in progress
//  cfg_bit_period_i in   16   clocks per bit minus 1; values <3 are clamped to 3
//  cfg_data_bits_i  in   2    00=5, 01=6, 10=7, 11=8 data bits
//  cfg_parity_i     in   2    00=none, 01=even, 10=odd, 11=none
//  cfg_stop2_i      in   1    1 = two stop bits
//  rx_en_i          in   1    receiver enable
//  uart_rxd_i       in   1    asynchronous serial input, idle high
//  m_valid_o        out  1    FIFO not empty
//  m_ready_i        in   1    consumer pops on m_valid_o && m_ready_i
//  m_data_o         out  8    head data, right-aligned, unused MSBs zero
//  m_err_o          out  2    head flags {framing, parity}
//  fifo_level_o     out  $clog2(FIFO_DEPTH)+1  entries held
//  overrun_o        out  1    sticky: a frame was dropped because the FIFO was full
//  overrun_clr_i    in   1    clears overrun_o
//  busy_o           out  1    FSM not in IDLE
//  break_o          out  1    break detected, 1-cycle pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; bit_period = DEFAULT_BIT_PERIOD; FIFO empty; sync flops = 1.
//  Format inputs are captured at start-bit detection and are stable for the whole frame.
//  Counter: 16-bit down-counter. START loads bit_period>>1; later states reload bit_period
//    and sample rxd when the counter reaches 0, which is mid-bit.
//  FSM states and transitions:
//   - IDLE: synced rxd = 0 -> START.
//   - START: sample 1 = glitch, go to IDLE with no push; sample 0 -> DATA.
//   - DATA: LSB first, one sample per bit until N bits -> PARITY if enabled, else STOP1.
//   - PARITY: parity flag = computed parity != sampled bit.
//   - STOP1: sample 0 sets framing flag; -> STOP2 if cfg_stop2_i, else PUSH.
//   - STOP2: same check; -> PUSH.
//   - PUSH: one cycle; writes {flags, data} to FIFO -> IDLE.
//  The final stop bit is sampled mid-bit, so a start bit immediately after it is caught.
//  FIFO is first-word fall-through: m_data_o and m_valid_o update 1 cycle after PUSH.
//  FIFO full at PUSH: frame dropped and overrun_o <= 1.
//    Exception: a pop in the same cycle frees a slot, the push is accepted, no overrun.
//  overrun_clr_i and an overrun in the same cycle: set wins.
//  Push and pop in the same cycle: level unchanged; pointers wrap modulo FIFO_DEPTH.
//  cfg_wr_i: FSM -> IDLE, partial frame discarded, new period used from the next start bit.
//    FIFO and overrun_o are untouched.
//  rx_en_i = 0: FSM held in IDLE and any partial frame discarded; FIFO can still be drained.
// CONFIGURATION
//  UART_RX_BREAK_DET_EN defined:
//   - A frame with all data bits 0 and framing error set is a break.
//   - The break is not pushed; break_o pulses 1 cycle.
//   - FSM waits for synced rxd = 1 before re-arming IDLE.
//  UART_RX_BREAK_DET_EN undefined:
//   - break_o tied to 0.
//   - A break is pushed as data 0x00 with m_err_o = 2'b10; FSM returns to IDLE normally.
// TESTING
//  - 8N1, default period 433: send 0xA5 -> one entry, m_data_o = 0xA5, m_err_o = 00.
//  - 7E1, send 0x35 with wrong parity bit -> m_data_o = 0x35, m_err_o = 01.
//    Same frame with correct parity -> m_err_o = 00.
//  - 8N2 with second stop bit driven 0 -> m_err_o = 10.
//    5N1, send 0x1F -> m_data_o = 0x1F.
//  - m_ready_i = 0, send 9 frames 0x00..0x08 -> level 8, overrun_o = 1.
//    Drain yields 0x00..0x07 in order; overrun_clr_i -> overrun_o = 0.
//  - rxd low for 100 cycles at period 433 -> no push, busy_o back to 0.
//    cfg_wr_i mid-frame -> no push; next frame at the new period is received correctly.
//  - UART_RX_BREAK_DET_EN: rxd low for 12 bit times -> break_o pulse, no push.
//    Without the macro: entry 0x00 with m_err_o = 10.

Source files
------------

// File: rtl/uart_rx_fifo_cfg.sv
// UART receiver with runtime frame format, mid-bit sampling and a first-word fall-through RX FIFO.
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_fifo_cfg #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_wr_i,
    input  logic [15:0]                   cfg_bit_period_i,
    input  logic [1:0]                    cfg_data_bits_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic                          rx_en_i,
    input  logic                          uart_rxd_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [7:0]                    m_data_o,
    output logic [1:0]                    m_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overrun_o,
    input  logic                          overrun_clr_i,
    output logic                          busy_o,
    output logic                          break_o
);
    localparam logic [15:0] DEFAULT_BIT_PERIOD = 16'(CLK_FREQ / BAUD_RATE - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BRK_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [15:0]            r_bit_period;
    state_t                 r_state;
    logic [15:0]            r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_data;
    logic                   r_perr;
    logic                   r_ferr;
    logic [1:0]             r_nbits;
    logic [1:0]             r_par_mode;
    logic                   r_stop2;

    logic w_rxd, w_abort, w_cnt_zero, w_last_bit, w_par_en, w_par_calc;

    assign w_rxd      = r_sync[SYNC_STAGES-1];
    assign w_abort    = cfg_wr_i || !rx_en_i;
    assign w_cnt_zero = (r_cnt == 16'd0);
    assign w_last_bit = (r_bit_idx == ({1'b0, r_nbits} + 3'd4));
    assign w_par_en   = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
    // Unreceived MSBs of r_data are zero, so reducing all 8 bits is safe.
    assign w_par_calc = (^r_data) ^ (r_par_mode == 2'b10);

`ifdef UART_RX_BREAK_DET_EN
    logic r_break;
    logic w_break;
    assign w_break = (r_data == 8'h00) && r_ferr;
    assign break_o = r_break;
`else
    assign break_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rxd_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        r_bit_period <= DEFAULT_BIT_PERIOD;
        else if (cfg_wr_i) r_bit_period <= (cfg_bit_period_i < 16'd3) ? 16'd3 : cfg_bit_period_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_data     <= 8'h00;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_nbits    <= 2'b00;
            r_par_mode <= 2'b00;
            r_stop2    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_break    <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_DET_EN
            r_break <= 1'b0;
`endif
            if (!w_cnt_zero) r_cnt <= r_cnt - 16'd1;
            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (!w_rxd) begin
                        r_state    <= S_START;
                        r_cnt      <= r_bit_period >> 1;
                        r_bit_idx  <= 3'd0;
                        r_data     <= 8'h00;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_nbits    <= cfg_data_bits_i;
                        r_par_mode <= cfg_parity_i;
                        r_stop2    <= cfg_stop2_i;
                    end
                    S_START: if (w_cnt_zero) begin
                        r_cnt   <= r_bit_period;
                        r_state <= w_rxd ? S_IDLE : S_DATA;
                    end
                    S_DATA: if (w_cnt_zero) begin
                        r_data[r_bit_idx] <= w_rxd;
                        r_cnt             <= r_bit_period;
                        if (w_last_bit) r_state <= w_par_en ? S_PARITY : S_STOP1;
                        else            r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    S_PARITY: if (w_cnt_zero) begin
                        r_perr  <= (w_par_calc != w_rxd);
                        r_cnt   <= r_bit_period;
                        r_state <= S_STOP1;
                    end
                    S_STOP1: if (w_cnt_zero) begin
                        if (!w_rxd) r_ferr <= 1'b1;
                        r_cnt   <= r_bit_period;
                        r_state <= r_stop2 ? S_STOP2 : S_PUSH;
                    end
                    S_STOP2: if (w_cnt_zero) begin
                        if (!w_rxd) r_ferr <= 1'b1;
                        r_state <= S_PUSH;
                    end
`ifdef UART_RX_BREAK_DET_EN
                    S_PUSH: if (w_break) begin
                        r_break <= 1'b1;
                        r_state <= S_BRK_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    S_PUSH: r_state <= S_IDLE;
`endif
                    // Line must return high before a new start bit is accepted.
                    S_BRK_WAIT: if (w_rxd) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overrun;
    logic          w_push_req, w_full, w_pop, w_push, w_overrun;
    logic [9:0]    w_head;

`ifdef UART_RX_BREAK_DET_EN
    assign w_push_req = (r_state == S_PUSH) && !w_abort && !w_break;
`else
    assign w_push_req = (r_state == S_PUSH) && !w_abort;
`endif
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_pop     = (r_level != '0) && m_ready_i;
    // A same-cycle pop frees the slot the push needs.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_overrun = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_ferr, r_perr, r_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_overrun)          r_overrun <= 1'b1;
            else if (overrun_clr_i) r_overrun <= 1'b0;
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign m_valid_o    = (r_level != '0);
    assign m_data_o     = m_valid_o ? w_head[7:0] : 8'h00;
    assign m_err_o      = m_valid_o ? w_head[9:8] : 2'b00;
    assign fifo_level_o = r_level;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != S_IDLE);
endmodule
